// File: rtl/fsm_lockstep_ctrl.sv
// Lockstep sequencer/checker for the 5-state FSM (2->6->7->5->4): drives reset and 'a' to three
// implementations, tracks a golden model and latches the first divergence.
module fsm_lockstep_ctrl #(
  parameter int STEPS = 16,
  parameter int PAT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [2:0]       s_beh,
  input  logic [2:0]       s_gate,
  input  logic [2:0]       s_mem,
  output logic             dut_res,
  output logic             dut_a,
  output logic [2:0]       gold,
  output logic [4:0]       step_cnt,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [4:0]       fail_step,
  output logic [2:0]       fail_mask,
  output logic             illegal
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_FAIL = 2'd3;

  localparam logic [2:0] G_RST = 3'd2;
  localparam logic [4:0] LAST_STEP = 5'(STEPS);

  logic [1:0]       r_state;
  logic [1:0]       w_nxt_state;
  logic [PAT_W-1:0] r_pat_sh;
  logic [2:0]       r_gold;
  logic [4:0]       r_step;
  logic             r_dut_res;
  logic [4:0]       r_fail_step;
  logic [2:0]       r_fail_mask;
  logic             r_illegal;
  logic [2:0]       w_mask;
  logic             w_dut_a;
  logic             w_any_illegal;

  function automatic logic [2:0] f_gold_next(input logic [2:0] cur, input logic a);
    case (cur)
      3'd2:    f_gold_next = 3'd6;
      3'd6:    f_gold_next = a ? 3'd7 : 3'd5;
      3'd7:    f_gold_next = 3'd5;
      3'd5:    f_gold_next = 3'd4;
      3'd4:    f_gold_next = a ? 3'd6 : 3'd2;
      default: f_gold_next = G_RST;
    endcase
  endfunction

  // Encodings 0, 1 and 3 are never part of the legal cycle.
  function automatic logic f_is_illegal(input logic [2:0] s);
    f_is_illegal = (s == 3'd0) || (s == 3'd1) || (s == 3'd3);
  endfunction

  assign w_mask        = {s_mem != r_gold, s_gate != r_gold, s_beh != r_gold};
  assign w_dut_a       = (r_state == ST_RUN) && r_pat_sh[0];
  assign w_any_illegal = f_is_illegal(s_beh) || f_is_illegal(s_gate) || f_is_illegal(s_mem);

  always_comb begin
    w_nxt_state = r_state;
    if (r_state == ST_RUN) begin
      if (|w_mask)                  w_nxt_state = ST_FAIL;
      else if (r_step == LAST_STEP) w_nxt_state = ST_DONE;
    end else if (start) begin
      w_nxt_state = ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_pat_sh    <= '0;
      r_gold      <= G_RST;
      r_step      <= '0;
      r_dut_res   <= 1'b0;
      r_fail_step <= '0;
      r_fail_mask <= '0;
      r_illegal   <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      // DUT reset releases on the same edge that enters RUN, so step 0 sees them at 2.
      r_dut_res <= (w_nxt_state == ST_RUN);
      if (r_state == ST_RUN) begin
        if (|w_mask) begin
          r_fail_step <= r_step;
          r_fail_mask <= w_mask;
          r_illegal   <= w_any_illegal;
        end else if (r_step != LAST_STEP) begin
          r_gold   <= f_gold_next(r_gold, w_dut_a);
          r_pat_sh <= r_pat_sh >> 1;
          r_step   <= r_step + 5'd1;
        end
      end else if (start) begin
        r_pat_sh    <= pattern;
        r_step      <= '0;
        r_gold      <= G_RST;
        r_fail_step <= '0;
        r_fail_mask <= '0;
        r_illegal   <= 1'b0;
      end
    end
  end

  assign dut_res   = r_dut_res;
  assign dut_a     = w_dut_a;
  assign gold      = r_gold;
  assign step_cnt  = r_step;
  assign busy      = (r_state == ST_RUN);
  assign done      = (r_state == ST_DONE);
  assign fail      = (r_state == ST_FAIL);
  assign fail_step = r_fail_step;
  assign fail_mask = r_fail_mask;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_fsm_lockstep_ctrl.sv
// Directed bench for fsm_lockstep_ctrl: a reference FSM stands in for the three implementations,
// with per-implementation overrides to plant divergences.
module tb_fsm_lockstep_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] pattern;
  logic [2:0]  s_beh, s_gate, s_mem;
  logic        dut_res, dut_a;
  logic [2:0]  gold;
  logic [4:0]  step_cnt;
  logic        busy, done, fail;
  logic [4:0]  fail_step;
  logic [2:0]  fail_mask;
  logic        illegal;

  logic [2:0]  s_ref;
  logic        inj_gate, inj_mem;
  int          n_checks = 0;
  int          n_errors = 0;

  logic [2:0]  exp_p0  [0:16];
  logic [2:0]  exp_ff  [0:16];
  logic [2:0]  exp_08  [0:16];
  logic [2:0]  exp_cur [0:16];

  fsm_lockstep_ctrl #(.STEPS(16), .PAT_W(16)) u_dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern),
    .s_beh(s_beh), .s_gate(s_gate), .s_mem(s_mem),
    .dut_res(dut_res), .dut_a(dut_a), .gold(gold), .step_cnt(step_cnt),
    .busy(busy), .done(done), .fail(fail), .fail_step(fail_step),
    .fail_mask(fail_mask), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Reference FSM playing the role of a correct implementation.
  always_ff @(posedge clk or negedge dut_res) begin
    if (!dut_res) s_ref <= 3'd2;
    else begin
      case (s_ref)
        3'd2:    s_ref <= 3'd6;
        3'd6:    s_ref <= dut_a ? 3'd7 : 3'd5;
        3'd7:    s_ref <= 3'd5;
        3'd5:    s_ref <= 3'd4;
        3'd4:    s_ref <= dut_a ? 3'd6 : 3'd2;
        default: s_ref <= 3'd2;
      endcase
    end
  end

  assign s_beh  = s_ref;
  assign s_gate = (inj_gate && busy && step_cnt == 5'd5) ? 3'd3 : s_ref;
  assign s_mem  = (inj_mem  && busy && step_cnt == 5'd0) ? 3'd6 : s_ref;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [15:0] p);
    @(negedge clk);
    pattern = p;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_pass(input string tag);
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      chk($sformatf("%s_gold%0d", tag, k), gold, exp_cur[k]);
      chk($sformatf("%s_step%0d", tag, k), step_cnt, k);
      chk($sformatf("%s_busy%0d", tag, k), busy, 1);
      chk($sformatf("%s_res%0d", tag, k), dut_res, 1);
    end
    @(negedge clk);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_fail"}, fail, 0);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_res_end"}, dut_res, 0);
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (!(done || fail) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_end_timeout"}, done | fail, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_res"}, dut_res, 0);
    chk({tag, "_a"}, dut_a, 0);
    chk({tag, "_gold"}, gold, 2);
    chk({tag, "_step"}, step_cnt, 0);
    chk({tag, "_flags"}, {busy, done, fail}, 0);
    chk({tag, "_fstep"}, fail_step, 0);
    chk({tag, "_fmask"}, fail_mask, 0);
    chk({tag, "_ill"}, illegal, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Hand-derived gold traces, steps 0..16.
    exp_p0 = '{3'd2,3'd6,3'd5,3'd4, 3'd2,3'd6,3'd5,3'd4, 3'd2,3'd6,3'd5,3'd4, 3'd2,3'd6,3'd5,3'd4, 3'd2};
    exp_ff = '{3'd2,3'd6,3'd7,3'd5, 3'd4,3'd6,3'd7,3'd5, 3'd4,3'd6,3'd7,3'd5, 3'd4,3'd6,3'd7,3'd5, 3'd4};
    exp_08 = '{3'd2,3'd6,3'd5,3'd4, 3'd6,3'd5,3'd4,3'd2, 3'd6,3'd5,3'd4,3'd2, 3'd6,3'd5,3'd4,3'd2, 3'd6};

    reset = 1'b0; start = 1'b0; pattern = '0; inj_gate = 1'b0; inj_mem = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst0");
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("idle");

    exp_cur = exp_p0;
    do_start(16'h0000);
    run_pass("p0");
    repeat (3) @(negedge clk);
    chk("p0_done_sticky", done, 1);

    exp_cur = exp_ff;
    do_start(16'hFFFF);
    run_pass("pff");

    exp_cur = exp_08;
    do_start(16'h0008);
    run_pass("p08");

    inj_gate = 1'b1;
    do_start(16'h0000);
    wait_end("gate");
    chk("gate_fail", fail, 1);
    chk("gate_done", done, 0);
    chk("gate_fstep", fail_step, 5);
    chk("gate_fmask", fail_mask, 3'b010);
    chk("gate_ill", illegal, 1);
    chk("gate_res", dut_res, 0);
    chk("gate_gold_hold", gold, 6);
    chk("gate_step_hold", step_cnt, 5);
    inj_gate = 1'b0;
    repeat (3) @(negedge clk);
    chk("gate_fail_sticky", fail, 1);

    inj_mem = 1'b1;
    do_start(16'h0000);
    chk("mem_clr_ill", illegal, 0);
    wait_end("mem");
    chk("mem_fail", fail, 1);
    chk("mem_fstep", fail_step, 0);
    chk("mem_fmask", fail_mask, 3'b100);
    chk("mem_ill", illegal, 0);
    chk("mem_gold_hold", gold, 2);
    inj_mem = 1'b0;

    do_start(16'h0000);
    chk("t6_fail_clr", fail, 0);
    chk("t6_fmask_clr", fail_mask, 0);
    for (int k = 0; k <= 3; k++) @(negedge clk);
    chk("t6_step3", step_cnt, 3);
    pattern = 16'hFFFF;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t6_ign_step", step_cnt, 4);
    chk("t6_ign_gold", gold, 2);
    chk("t6_ign_busy", busy, 1);
    for (int k = 5; k <= 7; k++) begin
      @(negedge clk);
      chk($sformatf("t6_gold%0d", k), gold, exp_p0[k]);
    end
    chk("t6_step7", step_cnt, 7);
    #1 reset = 1'b0;
    #1 chk_reset_vals("t6_abort");
    @(negedge clk);
    chk_reset_vals("t6_held");
    reset = 1'b1;
    exp_cur = exp_p0;
    do_start(16'h0000);
    run_pass("t6_rerun");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
